data_cache_ctrl: RTL
====================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, number of line-index bits (2**INDEX_BITS lines).
REQ-002 SHALL have one clock and synchronous active-high reset: clk input, rst input.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_data_addr1  input  28  CPU word address: [2:0] word offset, [INDEX_BITS+2:3] index, [27:INDEX_BITS+3] tag.
REQ-006 mem_data_wr1  input  32  CPU write data.
REQ-007 mem_rw_data1  input  1  1 = write, 0 = read.
REQ-008 mem_valid_data1  input  1  CPU command valid.
REQ-009 mem_data_rd1  output  32  read data, valid only while mem_ready_data1 = 1.
REQ-010 mem_ready_data1  output  1  one-cycle completion pulse.
REQ-011 ddr_addr  output  25  DDR line address (word address [27:3]).
REQ-012 ddr_wdata  output  256  line write data; word n sits at bits [32n+31:32n].
REQ-013 ddr_rdata  input  256  line read data, sampled when ddr_ready = 1.
REQ-014 ddr_rw  output  1  1 = line write, 0 = line read.
REQ-015 ddr_valid  output  1  DDR request valid.
REQ-016 ddr_ready  input  1  one-cycle DDR completion pulse.
REQ-017 hit_cnt, miss_cnt  output  16 each  saturating hit and miss counters.

Function
REQ-018 SHALL be a direct-mapped, write-back, write-allocate cache with 256-bit lines and per-line valid, dirty and tag state.
REQ-019 FSM states SHALL be IDLE, COMPARE, WRITEBACK, REFILL and RESP.
REQ-020 IDLE SHALL latch addr, wdata and rw when mem_valid_data1 = 1, then go to COMPARE.
REQ-021 COMPARE hit: a read SHALL load the addressed word into mem_data_rd1; a write SHALL update that word and set dirty; either SHALL go to RESP.
REQ-022 COMPARE miss: SHALL go to WRITEBACK if the line is valid and dirty, else to REFILL.
REQ-023 Each request SHALL bump hit_cnt or miss_cnt exactly once (in COMPARE, not the post-refill re-COMPARE); counters saturate at 16'hFFFF.
REQ-024 WRITEBACK SHALL drive ddr_valid = 1, ddr_rw = 1, ddr_addr = {stored tag, index}, ddr_wdata = the line, all stable until ddr_ready; on ddr_ready it SHALL go to REFILL.
REQ-025 REFILL SHALL drive ddr_valid = 1, ddr_rw = 0, ddr_addr = latched addr[27:3] until ddr_ready.
REQ-026 On ddr_ready in REFILL, SHALL write ddr_rdata into the line, set valid, clear dirty, store the tag and return to COMPARE.
REQ-027 RESP SHALL assert mem_ready_data1 for exactly one cycle, then go to IDLE.
REQ-028 Hit latency SHALL be 3 cycles: valid sampled at edge N, ready high in cycle N+2.
REQ-029 mem_valid_data1 SHALL be ignored outside IDLE; CPU inputs SHALL NOT be re-sampled mid-request.
REQ-030 ddr_valid SHALL be 0 in the cycle after ddr_ready; only one DDR transaction SHALL be outstanding.
REQ-031 mem_data_rd1 SHALL hold its last value outside the ready cycle.

Reset
REQ-032 rst SHALL clear all valid and dirty bits, state to IDLE, ddr_valid, ddr_rw, mem_ready_data1, hit_cnt and miss_cnt to 0, and ddr_addr, ddr_wdata and mem_data_rd1 to 0.
REQ-033 rst mid-transaction SHALL abandon it; ddr_valid SHALL be 0 in the cycle after rst is sampled; a late ddr_ready SHALL be ignored.

Structure
REQ-034 Package dcache_pkg SHALL hold the state enum, OFFSET_BITS = 3, LINE_W = 256, ADDR_W = 28, and the tag/index/offset field helpers.
REQ-035 Sub-module dcache_line_store SHALL hold the tag, valid, dirty and data arrays, with one read and one write port; the FSM stays in data_cache_ctrl.

Verification
REQ-036 After reset, read 28'h000_0008 with DDR model word0 = 32'hDEADBEEF -> REFILL at ddr_addr 25'h000_0001; mem_data_rd1 = 32'hDEADBEEF with ready; miss_cnt = 1.
REQ-037 Write 32'h010000FF to 28'h000_0008, then read it -> read hits, ready in cycle N+2, data 32'h010000FF, no ddr_valid; hit_cnt increments.
REQ-038 Then write 28'h100_0008 -> WRITEBACK to ddr_addr 25'h000_0001 with word0 = 32'h010000FF, then REFILL from 25'h020_0001; a later read of 28'h000_0008 returns 32'h010000FF from the DDR model.
REQ-039 DDR model delays ddr_ready 10 cycles -> ddr_valid, ddr_addr and ddr_wdata are stable throughout and mem_ready_data1 stays 0.
REQ-040 rst pulsed during REFILL with ddr_ready arriving 2 cycles later -> ddr_valid = 0 the next cycle, the late ready is ignored, and a re-read of 28'h000_0008 misses.
REQ-041 Write 28'h100_000B then 28'h100_000F, then read both -> words 3 and 7 of one line return the written values; miss_cnt increments once.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address-field helpers for the data cache
//
// Contents:
//   state_t        controller FSM states
//   OFFSET_BITS    word-offset bits inside a 256-bit line
//   LINE_W         line width in bits
//   ADDR_W         CPU word-address width
//   addr_offset / addr_index / addr_tag / line_addr  address field helpers
package dcache_pkg;

   localparam int OFFSET_BITS = 3;
   localparam int LINE_W      = 256;
   localparam int ADDR_W      = 28;
   localparam int WORD_W      = 32;
   localparam int LINE_ADDR_W = ADDR_W - OFFSET_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_REFILL,
      S_RESP
   } state_t;

   function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_BITS-1:0];
   endfunction

   // Index and tag widths depend on the instance parameter, so these return
   // full-width, right-justified fields that the caller slices down.
   function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                    input int index_bits);
      logic [ADDR_W-1:0] mask;
      mask = (ADDR_W'(1) << index_bits) - ADDR_W'(1);
      return (addr >> OFFSET_BITS) & mask;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                  input int index_bits);
      return addr >> (OFFSET_BITS + index_bits);
   endfunction

   function automatic logic [LINE_ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_BITS];
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - tag/valid/dirty/data arrays of the direct-mapped cache
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset (clears valid/dirty)
//   rd_idx                      read-port line index (asynchronous read)
//   rd_tag/rd_valid/rd_dirty    stored state of the indexed line
//   rd_data                     stored line data
//   wr_en, wr_idx               write-port enable and line index
//   wr_tag, wr_dirty, wr_data   new tag, dirty flag and line data; a write always sets valid
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int TAG_W      = ADDR_W - OFFSET_BITS - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic [TAG_W-1:0]      rd_tag,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [LINE_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic                  wr_dirty,
   input  logic [LINE_W-1:0]     wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid_bits;
   logic [LINES-1:0]  dirty_bits;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (wr_en) begin
         valid_bits[wr_idx] <= 1'b1;
         dirty_bits[wr_idx] <= wr_dirty;
      end
   end

   // Tag and data need no reset: they are only trusted while the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];
   assign rd_valid = valid_bits[rd_idx];
   assign rd_dirty = dirty_bits[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_data_addr1      CPU word address {tag, index, offset}
//   mem_data_wr1        CPU write data
//   mem_rw_data1        1 = write, 0 = read
//   mem_valid_data1     CPU command valid (sampled only in IDLE)
//   mem_data_rd1        read data, held between responses
//   mem_ready_data1     one-cycle completion pulse
//   ddr_addr            DDR line address
//   ddr_wdata/ddr_rdata line write / read data (word n at [32n+31:32n])
//   ddr_rw              1 = line write, 0 = line read
//   ddr_valid/ddr_ready DDR request valid / one-cycle completion
//   hit_cnt, miss_cnt   saturating hit and miss counters
module data_cache_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      mem_data_addr1,
   input  logic [WORD_W-1:0]      mem_data_wr1,
   input  logic                   mem_rw_data1,
   input  logic                   mem_valid_data1,
   output logic [WORD_W-1:0]      mem_data_rd1,
   output logic                   mem_ready_data1,
   output logic [LINE_ADDR_W-1:0] ddr_addr,
   output logic [LINE_W-1:0]      ddr_wdata,
   input  logic [LINE_W-1:0]      ddr_rdata,
   output logic                   ddr_rw,
   output logic                   ddr_valid,
   input  logic                   ddr_ready,
   output logic [15:0]            hit_cnt,
   output logic [15:0]            miss_cnt
);

   localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;

   state_t              state;
   logic [ADDR_W-1:0]   req_addr;
   logic [WORD_W-1:0]   req_wdata;
   logic                req_rw;
   logic                refilled;   // set while re-comparing after a refill so it is not counted again

   logic [ADDR_W-1:0]      idx_full;
   logic [ADDR_W-1:0]      tag_full;
   logic                   unused_hi;
   logic [INDEX_BITS-1:0]  req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic [OFFSET_BITS-1:0] req_off;
   logic [7:0]             word_lsb;

   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              rd_dirty;
   logic [LINE_W-1:0] rd_data;
   logic [WORD_W-1:0] rd_word;
   logic [LINE_W-1:0] merged_line;
   logic              hit;
   logic              ddr_done;

   logic              wr_en;
   logic              wr_dirty;
   logic [LINE_W-1:0] wr_data;

   assign idx_full  = addr_index(req_addr, INDEX_BITS);
   assign tag_full  = addr_tag(req_addr, INDEX_BITS);
   assign unused_hi = ^{idx_full[ADDR_W-1:INDEX_BITS], tag_full[ADDR_W-1:TAG_W]};
   assign req_idx   = idx_full[INDEX_BITS-1:0];
   assign req_tag   = tag_full[TAG_W-1:0];
   assign req_off   = addr_offset(req_addr);
   assign word_lsb  = {req_off, 5'b00000};

   dcache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (req_idx),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_dirty (wr_dirty),
      .wr_data  (wr_data)
   );

   assign rd_word  = rd_data[word_lsb +: WORD_W];
   assign hit      = rd_valid && (rd_tag == req_tag);
   // Gating with ddr_valid keeps a stray ready (e.g. one left over from before a reset) harmless.
   assign ddr_done = ddr_valid && ddr_ready;

   always_comb begin
      merged_line = rd_data;
      merged_line[word_lsb +: WORD_W] = req_wdata;
   end

   // Line store write port: write hits merge one word; refills load the whole line clean.
   always_comb begin
      wr_en    = 1'b0;
      wr_dirty = 1'b1;
      wr_data  = merged_line;
      if (state == S_COMPARE && hit && req_rw) begin
         wr_en = 1'b1;
      end else if (state == S_REFILL && ddr_done) begin
         wr_en    = 1'b1;
         wr_dirty = 1'b0;
         wr_data  = ddr_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         req_addr        <= '0;
         req_wdata       <= '0;
         req_rw          <= 1'b0;
         refilled        <= 1'b0;
         mem_data_rd1    <= '0;
         mem_ready_data1 <= 1'b0;
         ddr_addr        <= '0;
         ddr_wdata       <= '0;
         ddr_rw          <= 1'b0;
         ddr_valid       <= 1'b0;
         hit_cnt         <= '0;
         miss_cnt        <= '0;
      end else begin
         mem_ready_data1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_valid_data1) begin
                  req_addr  <= mem_data_addr1;
                  req_wdata <= mem_data_wr1;
                  req_rw    <= mem_rw_data1;
                  refilled  <= 1'b0;
                  state     <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (hit) begin
                  if (!refilled && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                  if (!req_rw) mem_data_rd1 <= rd_word;
                  mem_ready_data1 <= 1'b1;
                  state           <= S_RESP;
               end else begin
                  if (!refilled && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                  ddr_valid <= 1'b1;
                  if (rd_valid && rd_dirty) begin
                     ddr_rw    <= 1'b1;
                     ddr_addr  <= {rd_tag, req_idx};
                     ddr_wdata <= rd_data;
                     state     <= S_WRITEBACK;
                  end else begin
                     ddr_rw   <= 1'b0;
                     ddr_addr <= line_addr(req_addr);
                     state    <= S_REFILL;
                  end
               end
            end
            S_WRITEBACK: begin
               // Drop valid for a cycle so the refill shows up as a separate transaction.
               if (ddr_done) begin
                  ddr_valid <= 1'b0;
                  state     <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (!ddr_valid) begin
                  ddr_valid <= 1'b1;
                  ddr_rw    <= 1'b0;
                  ddr_addr  <= line_addr(req_addr);
               end else if (ddr_done) begin
                  ddr_valid <= 1'b0;
                  refilled  <= 1'b1;
                  state     <= S_COMPARE;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
